// File: rtl/norm_shift_left_pipe.sv
// norm_shift_left_pipe: S+1-stage valid/ready normalising left shifter (in_valid/in_ready/in_data -> out_valid/out_ready/out_data/out_lzc/out_zero/out_sign, clk, sync active-high rst); define NORM_SHIFT_SIGNED_IN_EN for two's-complement input with sign/magnitude split
module norm_shift_left_pipe #(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [S-1:0] out_lzc,
  output logic         out_zero,
  output logic         out_sign
);
  logic [S:0] v, z, sg, rdy;
  logic [N-1:0] d [0:S];
  logic [S-1:0] l [1:S];
  logic [S-1:0] lin [1:S];
  logic [N-1:0] mag;
  logic sgn, full;
`ifdef NORM_SHIFT_SIGNED_IN_EN
  always_comb begin
    sgn = in_data[N-1];
    mag = sgn ? -in_data : in_data;
  end
`else
  always_comb begin
    sgn = 1'b0;
    mag = in_data;
  end
`endif
  always_comb begin
    lin[1] = '0;
    for (int i = 0; i < N; i++) if (d[0][i]) lin[1] = S'(N - 1 - i);
    for (int k = 2; k <= S; k++) lin[k] = l[k-1];
  end
  always_comb begin
    full = 1'b1;
    rdy = '0;
    for (int k = S; k >= 0; k--) begin
      full = full && v[k];
      rdy[k] = out_ready || !full;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      z <= '0;
      sg <= '0;
      for (int k = 0; k <= S; k++) d[k] <= '0;
      for (int k = 1; k <= S; k++) l[k] <= '0;
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d[0] <= mag;
          z[0] <= ~|in_data;
          sg[0] <= sgn;
        end
      end
      for (int k = 1; k <= S; k++) begin
        if (rdy[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            d[k] <= lin[k][S-k] ? d[k-1] << (1 << (S - k)) : d[k-1];
            l[k] <= lin[k];
            z[k] <= z[k-1];
            sg[k] <= sg[k-1];
          end
        end
      end
    end
  end
  assign in_ready = rdy[0];
  assign out_valid = v[S];
  assign out_data = d[S];
  assign out_lzc = l[S];
  assign out_zero = z[S];
  assign out_sign = sg[S];
endmodule

// File: tb/tb_norm_shift_left_pipe.sv
// tb_norm_shift_left_pipe: table, corner-sequence and randomized scoreboard checks of norm_shift_left_pipe
module tb_norm_shift_left_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_zero, out_sign;
  logic [15:0] in_data, out_data;
  logic [3:0] out_lzc;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [15:0] d;
    logic [3:0] l;
    logic z;
    logic s;
  } exp_t;
  typedef struct packed {
    logic [15:0] in;
    exp_t e;
  } vec_t;
  exp_t q[$];
  always #5 clk = ~clk;
  norm_shift_left_pipe #(.N(16), .S(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lzc(out_lzc),
    .out_zero(out_zero), .out_sign(out_sign)
  );
  function automatic exp_t model(input logic [15:0] x);
    exp_t e;
    logic [15:0] m;
`ifdef NORM_SHIFT_SIGNED_IN_EN
    e.s = x[15];
    m = x[15] ? 16'(0 - x) : x;
`else
    e.s = 1'b0;
    m = x;
`endif
    e.z = (m == 0);
    e.l = 4'd0;
    if (!e.z) while (!m[15]) begin
      m = m << 1;
      e.l = e.l + 4'd1;
    end
    e.d = m;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic chk_out(input string nm, input exp_t e);
    chk({nm, ".data"}, 32'(out_data), 32'(e.d));
    chk({nm, ".lzc"}, 32'(out_lzc), 32'(e.l));
    chk({nm, ".zero"}, 32'(out_zero), 32'(e.z));
    chk({nm, ".sign"}, 32'(out_sign), 32'(e.s));
  endtask
  task automatic step(input logic r, input logic iv, input logic [15:0] id, input logic ordy);
    @(negedge clk);
    rst = r;
    in_valid = iv;
    in_data = id;
    out_ready = ordy;
    #1;
  endtask
  task automatic send_one(input string nm, input logic [15:0] x, input exp_t e);
    int lat;
    bit got;
    step(0, 1, x, 1);
    chk({nm, ".acc"}, 32'(in_ready), 1);
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 0, 1);
      lat++;
      if (out_valid) begin
        got = 1;
        chk_out(nm, e);
      end
    end
    chk({nm, ".lat"}, 32'(lat), 5);
  endtask
  initial begin
    vec_t tbl[6];
    logic [15:0] b2b[3];
    exp_t t;
    int acc, cnt, first, last;
    logic [15:0] x;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset.out_valid", 32'(out_valid), 0);
    chk_out("reset", '{16'h0000, 4'd0, 1'b0, 1'b0});
    chk("reset.in_ready", 32'(in_ready), 1);
`ifdef NORM_SHIFT_SIGNED_IN_EN
    tbl[0] = '{16'h0001, '{16'h8000, 4'd15, 1'b0, 1'b0}};
    tbl[1] = '{16'h0000, '{16'h0000, 4'd0, 1'b1, 1'b0}};
    tbl[2] = '{16'h00F0, '{16'hF000, 4'd8, 1'b0, 1'b0}};
    tbl[3] = '{16'h0003, '{16'hC000, 4'd14, 1'b0, 1'b0}};
    tbl[4] = '{16'h8000, '{16'h8000, 4'd0, 1'b0, 1'b1}};
    tbl[5] = '{16'hFFFF, '{16'h8000, 4'd15, 1'b0, 1'b1}};
`else
    tbl[0] = '{16'h0001, '{16'h8000, 4'd15, 1'b0, 1'b0}};
    tbl[1] = '{16'h0000, '{16'h0000, 4'd0, 1'b1, 1'b0}};
    tbl[2] = '{16'h00F0, '{16'hF000, 4'd8, 1'b0, 1'b0}};
    tbl[3] = '{16'h0003, '{16'hC000, 4'd14, 1'b0, 1'b0}};
    tbl[4] = '{16'h1000, '{16'h8000, 4'd3, 1'b0, 1'b0}};
    tbl[5] = '{16'hFFFF, '{16'hFFFF, 4'd0, 1'b0, 1'b0}};
`endif
    for (int i = 0; i < 6; i++) send_one($sformatf("tbl%0d", i), tbl[i].in, tbl[i].e);
    b2b[0] = 16'h0003;
    b2b[1] = 16'h1000;
    b2b[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, b2b[i], 1);
      chk("b2b.acc", 32'(in_ready), 1);
      if (in_ready) q.push_back(model(b2b[i]));
    end
    cnt = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 1);
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
        if (q.size() == 0) chk("b2b.extra", 32'(out_valid), 0);
        else begin
          t = q.pop_front();
          chk_out("b2b", t);
        end
      end
    end
    chk("b2b.count", 32'(cnt), 3);
    chk("b2b.span", 32'(last - first), 2);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      x = 16'(32'h3 << i);
      step(0, 1, x, 0);
      if (in_ready) begin
        acc++;
        q.push_back(model(x));
      end
    end
    chk("bp.accepted", 32'(acc), 5);
    chk("bp.in_ready", 32'(in_ready), 0);
    chk("bp.out_valid", 32'(out_valid), 1);
    if (q.size() > 0) chk_out("bp.hold", q[0]);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1);
      if (out_valid) begin
        if (q.size() == 0) chk("bp.extra", 32'(out_valid), 0);
        else begin
          t = q.pop_front();
          chk_out("bp.drain", t);
        end
      end
    end
    chk("bp.left", 32'(q.size()), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0040 + 16'(i), 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk_out("rst", '{16'h0000, 4'd0, 1'b0, 1'b0});
    chk("rst.in_ready", 32'(in_ready), 1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 1);
      if (out_valid) cnt++;
    end
    chk("rst.flushed", 32'(cnt), 0);
    q.delete();
    for (int i = 0; i < 400; i++) begin
      x = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 15) == 0) x = 16'h0000;
      if ($urandom_range(0, 15) == 0) x = 16'h8000;
      step(0, $urandom_range(0, 9) < 7, x, $urandom_range(0, 9) < 6);
      if (out_ready) chk("rnd.in_ready", 32'(in_ready), 1);
      if (out_valid) begin
        if (q.size() == 0) chk("rnd.spurious", 32'(out_valid), 0);
        else begin
          chk_out("rnd", q[0]);
          if (out_ready) t = q.pop_front();
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data));
    end
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 1);
      if (out_valid) begin
        if (q.size() == 0) chk("rnd.extra", 32'(out_valid), 0);
        else begin
          t = q.pop_front();
          chk_out("rnd.drain", t);
        end
      end
    end
    chk("rnd.left", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
